// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types and constants for the instruction fetch controller
package ifetch_pkg;

    localparam int IFETCH_DATA_W      = 32;
    localparam int IFETCH_INSTR_BYTES = 4;
    localparam int IFETCH_MAX_WAIT    = 255;
    localparam int WAIT_CNT_W         = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        ERR  = 3'd4
    } ifetch_state_t;

endpackage

// File: rtl/ifetch_if.sv
// rtl/ifetch_if.sv - instruction memory and decode handshake bundle
interface ifetch_if
    import ifetch_pkg::*;
#(
    parameter int DATA_W = IFETCH_DATA_W
);
    logic              imem_req;
    logic [DATA_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] instr_pc;
    logic              instr_ready;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_gnt, imem_rvalid, imem_rdata, instr_ready
    );
endinterface

// File: rtl/ifetch_timeout.sv
// rtl/ifetch_timeout.sv - saturating wait counter with registered expiry flag
module ifetch_timeout
    import ifetch_pkg::*;
#(
    parameter int MAX_WAIT = IFETCH_MAX_WAIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  expired_q, expired_d;

    // Counting stops once expired so a held-off timeout cannot wrap back to zero.
    always_comb begin
        cnt_d     = cnt_q;
        expired_d = expired_q;
        if (clr_i) begin
            cnt_d     = '0;
            expired_d = 1'b0;
        end else if (en_i && !expired_q) begin
            cnt_d     = cnt_q + 1'b1;
            expired_d = (cnt_d == WAIT_CNT_W'(MAX_WAIT));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/ifetch_ctrl.sv
// rtl/ifetch_ctrl.sv - fetch FSM driving next-PC, imem handshake and decode output
// Optional redirect alignment check enabled by defining IFETCH_ALIGN_CHK_EN.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int DATA_W      = IFETCH_DATA_W,
    parameter int INSTR_BYTES = IFETCH_INSTR_BYTES,
    parameter int MAX_WAIT    = IFETCH_MAX_WAIT
) (
    input  logic              pc_clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pc_in,
    output logic [DATA_W-1:0] pc_next,
    input  logic              redirect_valid,
    input  logic [DATA_W-1:0] redirect_target,
    output logic              fetch_err,
    ifetch_if.master          bus
);

    ifetch_state_t     state_q, state_d;
    logic              kill_q, kill_d;
    logic [DATA_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] instr_pc_q, instr_pc_d;
    logic              timeout;
    logic              redir_bad;
    logic              req;

`ifdef IFETCH_ALIGN_CHK_EN
    assign redir_bad = redirect_valid && (redirect_target[1:0] != 2'b00);
`else
    assign redir_bad = 1'b0;
`endif

    ifetch_timeout #(.MAX_WAIT(MAX_WAIT)) u_timeout (
        .clk       (pc_clk),
        .rst       (rst),
        .clr_i     (state_d != WAIT),
        .en_i      (state_q == WAIT),
        .expired_o (timeout)
    );

    always_comb begin
        state_d    = state_q;
        kill_d     = kill_q;
        fetch_pc_d = fetch_pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        pc_next    = pc_in;
        req        = 1'b0;
        fetch_err  = 1'b0;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                req = !redirect_valid;
                if (req && bus.imem_gnt) begin
                    fetch_pc_d = pc_in;
                    pc_next    = pc_in + DATA_W'(INSTR_BYTES);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_rvalid) begin
                    if (kill_q || redirect_valid) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        instr_d    = bus.imem_rdata;
                        instr_pc_d = fetch_pc_q;
                        state_d    = HOLD;
                    end
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                end else if (timeout) begin
                    fetch_err = 1'b1;
                    state_d   = ERR;
                end
            end
            HOLD: if (bus.instr_ready) state_d = REQ;
            ERR:  state_d = ERR;
            default: state_d = IDLE;
        endcase

        // Redirect overrides everything; an unanswered request keeps WAIT to drain its response.
        if (redirect_valid) begin
            if (redir_bad) begin
                fetch_err = 1'b1;
                pc_next   = pc_in;
                state_d   = ERR;
            end else begin
                pc_next = redirect_target;
                if (!(state_q == WAIT && !bus.imem_rvalid)) state_d = REQ;
            end
        end
    end

    always_ff @(posedge pc_clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            kill_q     <= 1'b0;
            fetch_pc_q <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            kill_q     <= kill_d;
            fetch_pc_q <= fetch_pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc_in;
    assign bus.instr_valid = (state_q == HOLD);
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb/tb_ifetch_ctrl.sv - directed self-checking bench for ifetch_ctrl
module tb_ifetch_ctrl;

    logic        pc_clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in;
    logic [31:0] pc_next;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        fetch_err;

    int checks = 0;
    int passes = 0;

    ifetch_if dif ();

    ifetch_ctrl dut (
        .pc_clk          (pc_clk),
        .rst             (rst),
        .pc_in           (pc_in),
        .pc_next         (pc_next),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .fetch_err       (fetch_err),
        .bus             (dif.master)
    );

    always #5 pc_clk = ~pc_clk;

    // Program-counter register that the controller steers.
    always_ff @(posedge pc_clk or posedge rst) begin
        if (rst) pc_in <= 32'h0;
        else     pc_in <= pc_next;
    end

    task automatic cyc();
        @(negedge pc_clk);
        dif.imem_gnt    = 1'b0;
        dif.imem_rvalid = 1'b0;
        dif.imem_rdata  = 32'h0;
        dif.instr_ready = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
    endtask

    task automatic test_reset();
        cyc(); cyc(); cyc();
        #1;
        checks++; if (dif.imem_req !== 1'b0) $display("FAIL rst_req got %0h exp 0", dif.imem_req); else passes++;
        checks++; if (dif.instr_valid !== 1'b0) $display("FAIL rst_valid got %0h exp 0", dif.instr_valid); else passes++;
        checks++; if (dif.instr !== 32'h0) $display("FAIL rst_instr got %h exp 0", dif.instr); else passes++;
        checks++; if (dif.instr_pc !== 32'h0) $display("FAIL rst_instr_pc got %h exp 0", dif.instr_pc); else passes++;
        checks++; if (fetch_err !== 1'b0) $display("FAIL rst_err got %0h exp 0", fetch_err); else passes++;
        checks++; if (pc_next !== 32'h0) $display("FAIL rst_pc_next got %h exp 0", pc_next); else passes++;
    endtask

    task automatic test_reset_fetch();
        cyc(); rst = 1'b0; #1;
        checks++; if (dif.imem_req !== 1'b0) $display("FAIL idle_req got %0h exp 0", dif.imem_req); else passes++;
        cyc(); dif.imem_gnt = 1'b1; #1;
        checks++; if (dif.imem_req !== 1'b1) $display("FAIL rf_req got %0h exp 1", dif.imem_req); else passes++;
        checks++; if (dif.imem_addr !== 32'h0) $display("FAIL rf_addr got %h exp 0", dif.imem_addr); else passes++;
        checks++; if (pc_next !== 32'h4) $display("FAIL rf_pc_next got %h exp 4", pc_next); else passes++;
        cyc(); dif.imem_rvalid = 1'b1; dif.imem_rdata = 32'h13; #1;
        checks++; if (dif.instr_valid !== 1'b0) $display("FAIL rf_wait_valid got %0h exp 0", dif.instr_valid); else passes++;
        cyc(); #1;
        checks++; if (dif.instr_valid !== 1'b1) $display("FAIL rf_valid got %0h exp 1", dif.instr_valid); else passes++;
        checks++; if (dif.instr !== 32'h13) $display("FAIL rf_instr got %h exp 00000013", dif.instr); else passes++;
        checks++; if (dif.instr_pc !== 32'h0) $display("FAIL rf_instr_pc got %h exp 0", dif.instr_pc); else passes++;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) cyc();
            #1;
            checks++; if (dif.instr_valid !== 1'b1) $display("FAIL bp_valid[%0d] got %0h exp 1", i, dif.instr_valid); else passes++;
            checks++; if (dif.instr !== 32'h13) $display("FAIL bp_instr[%0d] got %h exp 00000013", i, dif.instr); else passes++;
            checks++; if (dif.imem_req !== 1'b0) $display("FAIL bp_req[%0d] got %0h exp 0", i, dif.imem_req); else passes++;
            checks++; if (pc_next !== 32'h4) $display("FAIL bp_pc_next[%0d] got %h exp 4", i, pc_next); else passes++;
        end
        cyc(); dif.instr_ready = 1'b1; #1;
        checks++; if (dif.instr_valid !== 1'b1) $display("FAIL bp_accept_valid got %0h exp 1", dif.instr_valid); else passes++;
    endtask

    task automatic test_redirect_wait();
        cyc(); dif.imem_gnt = 1'b1; #1;
        checks++; if (dif.imem_addr !== 32'h4) $display("FAIL rw_addr4 got %h exp 4", dif.imem_addr); else passes++;
        cyc(); dif.imem_rvalid = 1'b1; dif.imem_rdata = 32'h11;
        cyc(); dif.instr_ready = 1'b1; #1;
        checks++; if (dif.instr_pc !== 32'h4) $display("FAIL rw_instr_pc got %h exp 4", dif.instr_pc); else passes++;
        cyc(); dif.imem_gnt = 1'b1; #1;
        checks++; if (dif.imem_addr !== 32'h8) $display("FAIL rw_addr8 got %h exp 8", dif.imem_addr); else passes++;
        cyc(); redirect_valid = 1'b1; redirect_target = 32'h100; #1;
        checks++; if (pc_next !== 32'h100) $display("FAIL rw_pc_next got %h exp 100", pc_next); else passes++;
        cyc(); dif.imem_rvalid = 1'b1; dif.imem_rdata = 32'hDEAD; #1;
        checks++; if (pc_next !== 32'h100) $display("FAIL rw_hold got %h exp 100", pc_next); else passes++;
        cyc(); #1;
        checks++; if (dif.instr_valid !== 1'b0) $display("FAIL rw_dropped got %0h exp 0", dif.instr_valid); else passes++;
        checks++; if (dif.imem_req !== 1'b1) $display("FAIL rw_req got %0h exp 1", dif.imem_req); else passes++;
        checks++; if (dif.imem_addr !== 32'h100) $display("FAIL rw_addr100 got %h exp 100", dif.imem_addr); else passes++;
    endtask

    task automatic test_same_cycle();
        cyc(); dif.imem_gnt = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h200; #1;
        checks++; if (dif.imem_req !== 1'b0) $display("FAIL sc_req_suppr got %0h exp 0", dif.imem_req); else passes++;
        checks++; if (pc_next !== 32'h200) $display("FAIL sc_pc_next got %h exp 200", pc_next); else passes++;
        cyc(); dif.imem_gnt = 1'b1; #1;
        checks++; if (dif.imem_addr !== 32'h200) $display("FAIL sc_addr got %h exp 200", dif.imem_addr); else passes++;
        checks++; if (pc_next !== 32'h204) $display("FAIL sc_inc got %h exp 204", pc_next); else passes++;
        cyc(); dif.imem_rvalid = 1'b1; dif.imem_rdata = 32'hBAD; redirect_valid = 1'b1; redirect_target = 32'h300; #1;
        checks++; if (pc_next !== 32'h300) $display("FAIL sc_rv_pc_next got %h exp 300", pc_next); else passes++;
        cyc(); #1;
        checks++; if (dif.instr_valid !== 1'b0) $display("FAIL sc_rv_valid got %0h exp 0", dif.instr_valid); else passes++;
        checks++; if (dif.imem_req !== 1'b1) $display("FAIL sc_rv_req got %0h exp 1", dif.imem_req); else passes++;
        checks++; if (dif.imem_addr !== 32'h300) $display("FAIL sc_rv_addr got %h exp 300", dif.imem_addr); else passes++;
    endtask

    task automatic test_timeout();
        int pulses = 0;
        int at = 0;
        cyc(); dif.imem_gnt = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            cyc(); #1;
            if (fetch_err === 1'b1) begin
                pulses++;
                at = n;
            end
        end
        checks++; if (pulses !== 1) $display("FAIL to_pulses got %0d exp 1", pulses); else passes++;
        checks++; if (at !== 256) $display("FAIL to_cycle got %0d exp 256", at); else passes++;
        cyc(); dif.imem_gnt = 1'b1; #1;
        checks++; if (dif.imem_req !== 1'b0) $display("FAIL to_err_req got %0h exp 0", dif.imem_req); else passes++;
        cyc(); redirect_valid = 1'b1; redirect_target = 32'h40; #1;
        checks++; if (pc_next !== 32'h40) $display("FAIL to_redir got %h exp 40", pc_next); else passes++;
        cyc(); dif.imem_gnt = 1'b1; #1;
        checks++; if (dif.imem_req !== 1'b1) $display("FAIL to_req got %0h exp 1", dif.imem_req); else passes++;
        checks++; if (dif.imem_addr !== 32'h40) $display("FAIL to_addr got %h exp 40", dif.imem_addr); else passes++;
        cyc(); dif.imem_rvalid = 1'b1; dif.imem_rdata = 32'h55;
        cyc(); dif.instr_ready = 1'b1; #1;
        checks++; if (dif.instr !== 32'h55) $display("FAIL to_instr got %h exp 55", dif.instr); else passes++;
        checks++; if (dif.instr_pc !== 32'h40) $display("FAIL to_instr_pc got %h exp 40", dif.instr_pc); else passes++;
    endtask

    task automatic test_wrap();
        cyc(); redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        cyc(); dif.imem_gnt = 1'b1; #1;
        checks++; if (dif.imem_addr !== 32'hFFFF_FFFC) $display("FAIL wr_addr got %h exp fffffffc", dif.imem_addr); else passes++;
        checks++; if (pc_next !== 32'h0) $display("FAIL wr_pc_next got %h exp 0", pc_next); else passes++;
        cyc(); dif.imem_rvalid = 1'b1; dif.imem_rdata = 32'h77;
        cyc(); dif.instr_ready = 1'b1; #1;
        checks++; if (dif.instr_pc !== 32'hFFFF_FFFC) $display("FAIL wr_instr_pc got %h exp fffffffc", dif.instr_pc); else passes++;
    endtask

    task automatic test_reset_mid();
        cyc(); dif.imem_gnt = 1'b1;
        cyc(); rst = 1'b1; #1;
        checks++; if (dif.imem_req !== 1'b0) $display("FAIL rm_req got %0h exp 0", dif.imem_req); else passes++;
        cyc(); rst = 1'b0; dif.imem_rvalid = 1'b1; dif.imem_rdata = 32'h99; #1;
        checks++; if (dif.imem_req !== 1'b0) $display("FAIL rm_idle_req got %0h exp 0", dif.imem_req); else passes++;
        cyc(); #1;
        checks++; if (dif.instr_valid !== 1'b0) $display("FAIL rm_valid got %0h exp 0", dif.instr_valid); else passes++;
        checks++; if (dif.instr !== 32'h0) $display("FAIL rm_instr got %h exp 0", dif.instr); else passes++;
        checks++; if (dif.imem_req !== 1'b1) $display("FAIL rm_req2 got %0h exp 1", dif.imem_req); else passes++;
        checks++; if (dif.imem_addr !== 32'h0) $display("FAIL rm_addr got %h exp 0", dif.imem_addr); else passes++;
    endtask

    task automatic test_misalign();
        cyc(); redirect_valid = 1'b1; redirect_target = 32'h102; #1;
`ifdef IFETCH_ALIGN_CHK_EN
        checks++; if (fetch_err !== 1'b1) $display("FAIL ma_err got %0h exp 1", fetch_err); else passes++;
        checks++; if (pc_next !== 32'h0) $display("FAIL ma_pc_next got %h exp 0", pc_next); else passes++;
        cyc(); dif.imem_gnt = 1'b1; #1;
        checks++; if (dif.imem_req !== 1'b0) $display("FAIL ma_err_req got %0h exp 0", dif.imem_req); else passes++;
        cyc(); redirect_valid = 1'b1; redirect_target = 32'h40; #1;
        checks++; if (pc_next !== 32'h40) $display("FAIL ma_recover got %h exp 40", pc_next); else passes++;
        cyc(); #1;
        checks++; if (dif.imem_addr !== 32'h40) $display("FAIL ma_addr got %h exp 40", dif.imem_addr); else passes++;
`else
        checks++; if (fetch_err !== 1'b0) $display("FAIL ma_err got %0h exp 0", fetch_err); else passes++;
        checks++; if (pc_next !== 32'h102) $display("FAIL ma_pc_next got %h exp 102", pc_next); else passes++;
        cyc(); #1;
        checks++; if (dif.imem_addr !== 32'h102) $display("FAIL ma_addr got %h exp 102", dif.imem_addr); else passes++;
`endif
        checks++; if (dif.imem_req !== 1'b1) $display("FAIL ma_req got %0h exp 1", dif.imem_req); else passes++;
    endtask

    initial begin
        dif.imem_gnt    = 1'b0;
        dif.imem_rvalid = 1'b0;
        dif.imem_rdata  = 32'h0;
        dif.instr_ready = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        test_reset();
        test_reset_fetch();
        test_backpressure();
        test_redirect_wait();
        test_same_cycle();
        test_timeout();
        test_wrap();
        test_reset_mid();
        test_misalign();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
